// File: rtl/register_file.sv
// Two-read, one-write register file with registered read ports and hardwired-zero register 0.
// Define REGFILE_BYPASS_EN to forward same-edge write data to a read of the same address.
module register_file #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b,
  output logic              rd_valid
);

  localparam int NREG = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs_q [NREG];
  logic [DATA_W-1:0] rd_a_q, rd_a_d;
  logic [DATA_W-1:0] rd_b_q, rd_b_d;
  logic              rd_vld_q, rd_vld_d;
  logic              wr_hit;

  // Register 0 is never written, so it stays at its reset value of zero.
  assign wr_hit = wr_en && (wr_addr != '0);

  always_comb begin
    rd_a_d   = rd_a_q;
    rd_b_d   = rd_b_q;
    rd_vld_d = rd_req;
    if (rd_req) begin
      rd_a_d = (rd_addr_a == '0) ? '0 : regs_q[rd_addr_a];
      rd_b_d = (rd_addr_b == '0) ? '0 : regs_q[rd_addr_b];
`ifdef REGFILE_BYPASS_EN
      if (wr_hit && (wr_addr == rd_addr_a)) rd_a_d = wr_data;
      if (wr_hit && (wr_addr == rd_addr_b)) rd_b_d = wr_data;
`endif
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
      rd_a_q   <= '0;
      rd_b_q   <= '0;
      rd_vld_q <= 1'b0;
    end else begin
      if (wr_hit) regs_q[wr_addr] <= wr_data;
      rd_a_q   <= rd_a_d;
      rd_b_q   <= rd_b_d;
      rd_vld_q <= rd_vld_d;
    end
  end

  assign rd_data_a = rd_a_q;
  assign rd_data_b = rd_b_q;
  assign rd_valid  = rd_vld_q;

endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file: directed table, reset corner cases and random traffic
// checked against an array-based reference model. Honours REGFILE_BYPASS_EN like the design.
module tb_register_file;

  localparam int DW = 8;
  localparam int AW = 3;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          rd_req;
  logic [AW-1:0] rd_addr_a, rd_addr_b;
  logic [DW-1:0] rd_data_a, rd_data_b;
  logic          rd_valid;

  register_file #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .reset(reset),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_req(rd_req), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .rd_data_a(rd_data_a), .rd_data_b(rd_data_b), .rd_valid(rd_valid)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    logic          rr;
    logic [AW-1:0] ra;
    logic [AW-1:0] rb;
    logic [DW-1:0] ea;
    logic [DW-1:0] eb;
    logic          ev;
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: register contents plus the values the read ports should show.
  logic [DW-1:0] mdl_mem [8];
  logic [DW-1:0] exp_a, exp_b;
  logic          exp_v;

  vec_t tbl [17];

  function automatic vec_t mk(input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                              input logic rr, input logic [AW-1:0] ra, input logic [AW-1:0] rb,
                              input logic [DW-1:0] ea, input logic [DW-1:0] eb, input logic ev);
    vec_t v;
    v.we = we; v.wa = wa; v.wd = wd; v.rr = rr; v.ra = ra; v.rb = rb;
    v.ea = ea; v.eb = eb; v.ev = ev;
    return v;
  endfunction

  function automatic logic [DW-1:0] model_read(input logic [AW-1:0] a, input logic we,
                                               input logic [AW-1:0] wa, input logic [DW-1:0] wd);
    if (a == 0) return '0;
    if (BYP && we && wa == a) return wd;
    return mdl_mem[a];
  endfunction

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, "_a"}, rd_data_a, exp_a);
    check({tag, "_b"}, rd_data_b, exp_b);
    check({tag, "_v"}, {7'd0, rd_valid}, {7'd0, exp_v});
  endtask

  // Drive one cycle of stimulus, advance the model, and return #1 after the edge.
  task automatic apply(input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                       input logic rr, input logic [AW-1:0] ra, input logic [AW-1:0] rb);
    wr_en = we; wr_addr = wa; wr_data = wd;
    rd_req = rr; rd_addr_a = ra; rd_addr_b = rb;
    exp_v = rr;
    if (rr) begin
      exp_a = model_read(ra, we, wa, wd);
      exp_b = model_read(rb, we, wa, wd);
    end
    @(posedge clk);
    #1;
    if (we && wa != 0) mdl_mem[wa] = wd;
  endtask

  initial begin
    for (int i = 0; i < 8; i++) mdl_mem[i] = '0;
    exp_a = '0; exp_b = '0; exp_v = 1'b0;
    reset = 1'b1;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    rd_req = 1'b0; rd_addr_a = '0; rd_addr_b = '0;

    // Reset held for two cycles.
    repeat (2) @(posedge clk);
    #1;
    check("reset_a", rd_data_a, 8'h00);
    check("reset_b", rd_data_b, 8'h00);
    check("reset_v", {7'd0, rd_valid}, 8'h00);
    reset = 1'b0;

    // Every register reads zero after reset, one rd_valid per read.
    for (int a = 0; a < 8; a++) begin
      apply(1'b0, '0, '0, 1'b1, AW'(a), AW'(7 - a));
      check("rst_rd_a", rd_data_a, 8'h00);
      check("rst_rd_b", rd_data_b, 8'h00);
      check("rst_rd_v", {7'd0, rd_valid}, 8'h01);
    end
    apply(1'b0, '0, '0, 1'b0, '0, '0);
    check("idle_v", {7'd0, rd_valid}, 8'h00);

    // Directed table: writes, zero register, same-edge hazard, burst reads, hold.
    tbl[0]  = mk(1, 3'd3, 8'hA5, 0, 3'd0, 3'd0, 8'h00, 8'h00, 0);
    tbl[1]  = mk(1, 3'd0, 8'h5A, 0, 3'd0, 3'd0, 8'h00, 8'h00, 0);
    tbl[2]  = mk(0, 3'd0, 8'h00, 1, 3'd3, 3'd0, 8'hA5, 8'h00, 1);
    tbl[3]  = mk(1, 3'd5, 8'h11, 0, 3'd0, 3'd0, 8'hA5, 8'h00, 0);
    tbl[4]  = mk(1, 3'd5, 8'h77, 1, 3'd5, 3'd5, BYP ? 8'h77 : 8'h11, BYP ? 8'h77 : 8'h11, 1);
    tbl[5]  = mk(0, 3'd0, 8'h00, 1, 3'd5, 3'd5, 8'h77, 8'h77, 1);
    tbl[6]  = mk(1, 3'd1, 8'h01, 0, 3'd0, 3'd0, 8'h77, 8'h77, 0);
    tbl[7]  = mk(1, 3'd2, 8'h02, 0, 3'd0, 3'd0, 8'h77, 8'h77, 0);
    tbl[8]  = mk(1, 3'd4, 8'h04, 0, 3'd0, 3'd0, 8'h77, 8'h77, 0);
    tbl[9]  = mk(0, 3'd0, 8'h00, 1, 3'd1, 3'd4, 8'h01, 8'h04, 1);
    tbl[10] = mk(0, 3'd0, 8'h00, 1, 3'd2, 3'd3, 8'h02, 8'hA5, 1);
    tbl[11] = mk(0, 3'd0, 8'h00, 1, 3'd3, 3'd2, 8'hA5, 8'h02, 1);
    tbl[12] = mk(0, 3'd0, 8'h00, 1, 3'd4, 3'd1, 8'h04, 8'h01, 1);
    tbl[13] = mk(0, 3'd0, 8'h00, 0, 3'd1, 3'd1, 8'h04, 8'h01, 0);
    tbl[14] = mk(0, 3'd0, 8'h00, 0, 3'd2, 3'd2, 8'h04, 8'h01, 0);
    tbl[15] = mk(1, 3'd2, 8'h33, 1, 3'd1, 3'd4, 8'h01, 8'h04, 1);
    tbl[16] = mk(0, 3'd0, 8'h00, 1, 3'd2, 3'd2, 8'h33, 8'h33, 1);
    for (int i = 0; i < 17; i++) begin
      apply(tbl[i].we, tbl[i].wa, tbl[i].wd, tbl[i].rr, tbl[i].ra, tbl[i].rb);
      check($sformatf("tbl%0d_a", i), rd_data_a, tbl[i].ea);
      check($sformatf("tbl%0d_b", i), rd_data_b, tbl[i].eb);
      check($sformatf("tbl%0d_v", i), {7'd0, rd_valid}, {7'd0, tbl[i].ev});
    end

    // Random traffic against the model.
    for (int n = 0; n < 300; n++) begin
      apply(1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)), DW'($urandom),
            1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)));
      check_model("rand");
    end

    // Fill, read back, then reset mid-cycle with a read pending.
    for (int a = 1; a < 8; a++) apply(1'b1, AW'(a), 8'hFF, 1'b0, '0, '0);
    apply(1'b0, '0, '0, 1'b1, 3'd7, 3'd6);
    check("pre_rst_a", rd_data_a, 8'hFF);
    check("pre_rst_b", rd_data_b, 8'hFF);
    rd_req = 1'b1; rd_addr_a = 3'd3; rd_addr_b = 3'd4;
    wr_en = 1'b1; wr_addr = 3'd1; wr_data = 8'h55;
    #2;
    reset = 1'b1;
    #1;
    check("async_rst_a", rd_data_a, 8'h00);
    check("async_rst_b", rd_data_b, 8'h00);
    check("async_rst_v", {7'd0, rd_valid}, 8'h00);
    @(posedge clk);
    #1;
    check("in_rst_a", rd_data_a, 8'h00);
    check("in_rst_v", {7'd0, rd_valid}, 8'h00);
    reset = 1'b0;
    for (int i = 0; i < 8; i++) mdl_mem[i] = '0;
    for (int a = 1; a < 8; a++) begin
      apply(1'b0, '0, '0, 1'b1, AW'(a), AW'(8 - a));
      check("post_rst_a", rd_data_a, 8'h00);
      check("post_rst_b", rd_data_b, 8'h00);
      check("post_rst_v", {7'd0, rd_valid}, 8'h01);
    end
    apply(1'b0, '0, '0, 1'b0, '0, '0);
    check("final_v", {7'd0, rd_valid}, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/register_file.md
REGISTER_FILE -- requirements
Module: register_file

Interface
REQ-001 Parameter DATA_W, default 8, width in bits of each register and data port.
REQ-002 Parameter ADDR_W, default 3, address width; register count is 2**ADDR_W (8 by default).
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  reset is asynchronous and active-high.
REQ-005 wr_en  input  1  write strobe, sampled on the rising edge of clk.
REQ-006 wr_addr  input  ADDR_W  destination register index.
REQ-007 wr_data  input  DATA_W  write data.
REQ-008 rd_req  input  1  read request for both read ports, sampled on the rising edge of clk.
REQ-009 rd_addr_a  input  ADDR_W  read port A register index.
REQ-010 rd_addr_b  input  ADDR_W  read port B register index.
REQ-011 rd_data_a  output  DATA_W  registered read data, port A.
REQ-012 rd_data_b  output  DATA_W  registered read data, port B.
REQ-013 rd_valid  output  1  high for exactly one cycle per accepted rd_req; indicates rd_data_a and rd_data_b are new.

Function
REQ-014 The block SHALL hold 2**ADDR_W registers of DATA_W bits each, built from rising-edge flops.
REQ-015 On a clk edge with wr_en=1 and wr_addr!=0, the block SHALL store wr_data into register[wr_addr].
REQ-016 Register 0 SHALL always read as 0; writes to address 0 SHALL be ignored.
REQ-017 Read latency SHALL be 1 cycle: rd_req=1 at edge N SHALL cause rd_data_a/b and rd_valid=1 to appear after edge N.
REQ-018 The block SHALL sample rd_addr_a and rd_addr_b on the same edge as rd_req.
REQ-019 When rd_req=0 at an edge, rd_valid SHALL be 0 after that edge, and rd_data_a and rd_data_b SHALL hold their previous values.
REQ-020 Back-to-back rd_req on consecutive cycles SHALL be accepted every cycle, with rd_valid held high continuously.
REQ-021 Both read ports SHALL operate independently; they MAY address the same register and SHALL return identical data when they do.
REQ-022 A write and a read of the same nonzero address on the same edge SHALL return the data defined in REQ-029 and REQ-030.
REQ-023 A write and a read of different addresses on the same edge SHALL not interact.
REQ-024 wr_en and rd_req SHALL be fully independent; both, either or neither MAY be active on any edge.

Reset
REQ-025 Asserting reset SHALL immediately, without waiting for a clk edge, clear all registers to 0.
REQ-026 Asserting reset SHALL likewise immediately set rd_data_a=0, rd_data_b=0 and rd_valid=0.
REQ-027 While reset is high, wr_en and rd_req SHALL be ignored.
REQ-028 The first edge after reset deasserts SHALL operate normally, and a read pending when reset asserted SHALL be discarded.

Configuration
REQ-029 With macro REGFILE_BYPASS_EN defined, a same-edge write and read of the same nonzero address SHALL return the new wr_data (write-through forwarding), on either port or both.
REQ-030 With REGFILE_BYPASS_EN undefined, the same case SHALL return the value the register held before the write, and the new value SHALL be visible from the next read onward.

Verification
REQ-031 Scenario: assert reset for 2 cycles, then read addresses 0..7 -> every read returns 0x00 with one rd_valid pulse per read.
REQ-032 Scenario: write 0xA5 to register 3, then 0x5A to register 0, then read A=3 and B=0 -> rd_data_a=0xA5, rd_data_b=0x00 one cycle after rd_req.
REQ-033 Scenario: register 5 holds 0x11; on one edge write 0x77 to register 5 and read A=B=5 -> both ports return 0x77 if REGFILE_BYPASS_EN is defined, otherwise 0x11; the next read returns 0x77 in both builds.
REQ-034 Scenario: rd_req high for 4 consecutive cycles with addresses 1,2,3,4 -> rd_valid high for 4 consecutive cycles carrying the 4 stored values in order; with rd_req low afterwards, data holds and rd_valid=0.
REQ-035 Scenario: write 0xFF to all nonzero registers, then assert reset mid-cycle between edges -> outputs drop to 0 before the next edge, and subsequent reads of 1..7 return 0x00.
